i2s_receiver: RTL and testbench

Serial-to-parallel I2S receiver: the capture end of the I2S link driven by `i2s_sound_test`. It runs directly on the I2S bit clock and samples `word_select` and `sound_bit_in` on every rising edge. It rebuilds one left/right sample pair per frame and presents both channels together with a one-cycle `sample_valid` pulse to the downstream audio-processing pipeline.

---
 rtl/i2s_pkg.sv | 18 +
 rtl/i2s_receiver_if.sv | 25 ++
 rtl/i2s_rx_deser.sv | 50 +++++
 rtl/i2s_receiver.sv | 123 ++++++++++++
 tb/tb_i2s_receiver.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared constants and types for the I2S receive path
package i2s_pkg;

    localparam int I2S_SLOT_WIDTH   = 32;
    localparam int I2S_SAMPLE_WIDTH = 24;

    typedef enum logic [1:0] {
        SYNC,
        LEFT,
        RIGHT
    } i2s_rx_state_t;

    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } i2s_ch_t;

endpackage

// File: rtl/i2s_receiver_if.sv
// rtl/i2s_receiver_if.sv - I2S serial inputs and parallel sample outputs of the receiver
interface i2s_receiver_if #(
    parameter int SAMPLE_WIDTH = i2s_pkg::I2S_SAMPLE_WIDTH,
    parameter int SLOT_WIDTH   = i2s_pkg::I2S_SLOT_WIDTH
);

    logic                              word_select;
    logic                              sound_bit_in;
    logic [SAMPLE_WIDTH-1:0]           left_sample;
    logic [SAMPLE_WIDTH-1:0]           right_sample;
    logic                              sample_valid;
    logic [$clog2(2*SLOT_WIDTH)-1:0]   bit_counter;
    logic                              frame_error;

    modport master (
        output word_select, sound_bit_in,
        input  left_sample, right_sample, sample_valid, bit_counter, frame_error
    );

    modport slave (
        input  word_select, sound_bit_in,
        output left_sample, right_sample, sample_valid, bit_counter, frame_error
    );

endinterface

// File: rtl/i2s_rx_deser.sv
// rtl/i2s_rx_deser.sv - MSB-first indexed capture of one channel slot plus its bit count
module i2s_rx_deser
    import i2s_pkg::*;
#(
    parameter int SAMPLE_WIDTH = I2S_SAMPLE_WIDTH,
    parameter int SLOT_WIDTH   = I2S_SLOT_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    capture,
    input  logic                    clear,
    input  logic                    bit_in,
    output logic [SAMPLE_WIDTH-1:0] work_next,
    output logic                    len_ok
);

    localparam int CW = $clog2(SLOT_WIDTH) + 1;
    localparam logic [CW-1:0] CNT_MAX = '1;

    logic [CW-1:0]           ch_cnt;
    logic [SAMPLE_WIDTH-1:0] work;

    // work_next includes this edge's bit so a closing WS edge hands over a complete word
    always_comb begin
        work_next = work;
        for (int i = 0; i < SAMPLE_WIDTH; i++) begin
            if (capture && ch_cnt == CW'(SAMPLE_WIDTH - 1 - i)) begin
                work_next[i] = bit_in;
            end
        end
    end

    assign len_ok = (ch_cnt == CW'(SLOT_WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work   <= '0;
            ch_cnt <= '0;
        end else if (clear) begin
            work   <= '0;
            ch_cnt <= '0;
        end else if (capture) begin
            work <= work_next;
            if (ch_cnt != CNT_MAX) begin
                ch_cnt <= ch_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2s_receiver.sv
// rtl/i2s_receiver.sv - I2S receiver top: WS framing FSM, sample delivery; I2S_RX_FRAME_CHECK_EN adds slot-length checking
module i2s_receiver
    import i2s_pkg::*;
#(
    parameter int SAMPLE_WIDTH = I2S_SAMPLE_WIDTH,
    parameter int SLOT_WIDTH   = I2S_SLOT_WIDTH
) (
    input  logic           serial_clk,
    input  logic           reset,
    i2s_receiver_if.slave  rx
);

    localparam int BW = $clog2(2 * SLOT_WIDTH);

    i2s_rx_state_t           state, state_nxt;
    i2s_ch_t                 ws, ws_q;
    logic                    ws_rise, ws_fall, capture, len_ok, drop;
    logic [SAMPLE_WIDTH-1:0] work_next, left_hold, left_q, right_q;
    logic [BW-1:0]           bit_cnt_q;
    logic                    valid_q;

    assign ws      = i2s_ch_t'(rx.word_select);
    assign ws_rise = (ws == CH_RIGHT) && (ws_q == CH_LEFT);
    assign ws_fall = (ws == CH_LEFT)  && (ws_q == CH_RIGHT);
    assign capture = (state != SYNC);

    i2s_rx_deser #(
        .SAMPLE_WIDTH (SAMPLE_WIDTH),
        .SLOT_WIDTH   (SLOT_WIDTH)
    ) u_deser (
        .clk       (serial_clk),
        .rst_n     (reset),
        .capture   (capture),
        .clear     (ws_rise | ws_fall),
        .bit_in    (rx.sound_bit_in),
        .work_next (work_next),
        .len_ok    (len_ok)
    );

    always_ff @(posedge serial_clk or negedge reset) begin
        if (!reset) begin
            state <= SYNC;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            SYNC:    if (ws_fall) state_nxt = LEFT;
            LEFT:    if (ws_rise) state_nxt = RIGHT;
            RIGHT:   if (ws_fall) state_nxt = LEFT;
            default: state_nxt = SYNC;
        endcase
    end

`ifdef I2S_RX_FRAME_CHECK_EN
    logic err_q, frame_err_q, bad_now;

    assign bad_now = capture && (ws_rise || ws_fall) && !len_ok;
    assign drop    = err_q || bad_now;

    // error is sticky across the left slot and resolved at the frame-closing WS fall
    always_ff @(posedge serial_clk or negedge reset) begin
        if (!reset) begin
            err_q       <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            if (state == RIGHT && ws_fall) begin
                err_q       <= 1'b0;
                frame_err_q <= drop;
            end else if (bad_now) begin
                err_q <= 1'b1;
            end
        end
    end

    assign rx.frame_error = frame_err_q;
`else
    logic unused_len_ok;

    assign unused_len_ok  = len_ok;
    assign drop           = 1'b0;
    assign rx.frame_error = 1'b0;
`endif

    always_ff @(posedge serial_clk or negedge reset) begin
        if (!reset) begin
            ws_q      <= CH_LEFT;
            left_hold <= '0;
            left_q    <= '0;
            right_q   <= '0;
            valid_q   <= 1'b0;
            bit_cnt_q <= '0;
        end else begin
            ws_q    <= ws;
            valid_q <= 1'b0;
            if (state == LEFT && ws_rise) begin
                left_hold <= work_next;
            end
            if (state == RIGHT && ws_fall && !drop) begin
                left_q  <= left_hold;
                right_q <= work_next;
                valid_q <= 1'b1;
            end
            if (ws_fall || state == SYNC) begin
                bit_cnt_q <= '0;
            end else if (bit_cnt_q == BW'(2 * SLOT_WIDTH - 1)) begin
                bit_cnt_q <= '0;
            end else begin
                bit_cnt_q <= bit_cnt_q + 1'b1;
            end
        end
    end

    assign rx.left_sample  = left_q;
    assign rx.right_sample = right_q;
    assign rx.sample_valid = valid_q;
    assign rx.bit_counter  = bit_cnt_q;

endmodule

// File: tb/tb_i2s_receiver.sv
// tb/tb_i2s_receiver.sv - randomized bench for i2s_receiver against a frame-level reference model
module tb_i2s_receiver;

    localparam int SLOT = 32;
    localparam int SW   = 24;
`ifdef I2S_RX_FRAME_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic serial_clk = 1'b0;
    logic rst_n;

    always #5 serial_clk = ~serial_clk;

    i2s_receiver_if #(.SAMPLE_WIDTH(SW), .SLOT_WIDTH(SLOT)) rx ();

    i2s_receiver #(.SAMPLE_WIDTH(SW), .SLOT_WIDTH(SLOT)) dut (
        .serial_clk (serial_clk),
        .reset      (rst_n),
        .rx         (rx)
    );

    int total = 0;
    int bad   = 0;

    // model state
    bit            synced;
    int            pos;
    bit            m_bad;
    logic [SW-1:0] m_left, exp_left, exp_right;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic logic [SW-1:0] expect_word(input logic [39:0] w, input int len);
        logic [SW-1:0] e = '0;
        for (int k = 0; k < SW; k++) begin
            if (k < len) e[SW-1-k] = w[39-k];
        end
        return e;
    endfunction

    task automatic model_reset();
        synced    = 1'b0;
        pos       = 0;
        m_bad     = 1'b0;
        m_left    = '0;
        exp_left  = '0;
        exp_right = '0;
    endtask

    task automatic check_outputs(input bit ev_v, input bit ev_e, input int exp_bc);
        check("valid", {31'd0, rx.sample_valid}, {31'd0, ev_v});
        check("frame_error", {31'd0, rx.frame_error}, {31'd0, ev_e});
        check("left", {8'd0, rx.left_sample}, {8'd0, exp_left});
        check("right", {8'd0, rx.right_sample}, {8'd0, exp_right});
        check("bit_counter", {26'd0, rx.bit_counter}, exp_bc);
    endtask

    // one channel slot; with close=1 the WS change rides on the slot's last bit (I2S one-bit lead)
    task automatic send_slot(input bit right, input logic [39:0] w, input int len, input bit close);
        bit last, ev_v, ev_e;
        int exp_bc;
        for (int j = 0; j < len; j++) begin
            last = close && (j == len - 1);
            @(negedge serial_clk);
            rx.word_select  = right ^ last;
            rx.sound_bit_in = w[39-j];
            @(posedge serial_clk);
            #1;
            ev_v = 1'b0;
            ev_e = 1'b0;
            if (right && last) begin
                if (synced) begin
                    if (CHK && (m_bad || len != SLOT)) begin
                        ev_e = 1'b1;
                    end else begin
                        exp_left  = m_left;
                        exp_right = expect_word(w, len);
                        ev_v      = 1'b1;
                    end
                end
                synced = 1'b1;
                pos    = 0;
                m_bad  = 1'b0;
                exp_bc = 0;
            end else begin
                if (!right && last) begin
                    m_left = expect_word(w, len);
                    m_bad  = (len != SLOT);
                end
                exp_bc = synced ? (pos + 1) % (2 * SLOT) : 0;
                if (synced) pos++;
            end
            check_outputs(ev_v, ev_e, exp_bc);
        end
    endtask

    task automatic send_frame(input logic [39:0] lw, input int ll, input logic [39:0] rw, input int rl);
        send_slot(1'b0, lw, ll, 1'b1);
        send_slot(1'b1, rw, rl, 1'b1);
    endtask

    function automatic logic [39:0] rnd_word();
        return {$urandom(), 8'($urandom())};
    endfunction

    function automatic int rnd_len();
        return ($urandom_range(0, 3) == 0) ? int'($urandom_range(18, 36)) : SLOT;
    endfunction

    initial begin
        rst_n           = 1'b0;
        rx.word_select  = 1'b0;
        rx.sound_bit_in = 1'b0;
        model_reset();
        repeat (3) @(posedge serial_clk);
        #1;
        check_outputs(1'b0, 1'b0, 0);
        @(negedge serial_clk);
        rst_n = 1'b1;

        // sync frame, then one delivered frame
        send_frame({24'hA5A5A5, 16'h0}, SLOT, {24'h5A5A5A, 16'h0}, SLOT);
        send_frame({24'hA5A5A5, 16'h0}, SLOT, {24'h5A5A5A, 16'h0}, SLOT);

        // continuous extreme-value frames
        for (int f = 0; f < 3; f++) begin
            send_frame({24'h800000, 16'h0}, SLOT, {24'h7FFFFF, 16'h0}, SLOT);
        end

        // shortened right slot, then a good frame
        send_frame(rnd_word(), SLOT, rnd_word(), 30);
        send_frame(rnd_word(), SLOT, rnd_word(), SLOT);

        // asynchronous reset at bit_counter == 40
        send_slot(1'b0, rnd_word(), SLOT, 1'b1);
        send_slot(1'b1, rnd_word(), 8, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs(1'b0, 1'b0, 0);
        repeat (3) @(posedge serial_clk);
        @(negedge serial_clk);
        rst_n = 1'b1;

        // resume mid right slot: nothing until ws_fall plus one frame
        send_slot(1'b1, rnd_word(), 12, 1'b1);
        send_frame(rnd_word(), SLOT, rnd_word(), SLOT);

        // 16-bit left slot zero-fills the LSBs
        send_frame({16'hBEEF, 24'h0}, 16, rnd_word(), SLOT);
        send_frame(rnd_word(), SLOT, rnd_word(), SLOT);

        // random data and occasional odd slot lengths
        for (int f = 0; f < 20; f++) begin
            send_frame(rnd_word(), rnd_len(), rnd_word(), rnd_len());
        end
        send_frame(rnd_word(), SLOT, rnd_word(), SLOT);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
